// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - memory-op encodings (mem_op_e), bus/register widths, TIMEOUT default
//   - stage register layout (stage_t) and FSM states (state_e)
//   - helpers classifying ops and detecting misaligned accesses
package mem_stage_pkg;

    localparam int DATA_BUS    = 32;
    localparam int REG_BUS     = 5;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef struct packed {
        logic                valid;
        mem_op_e             op;
        logic [DATA_BUS-1:0] addr;
        logic [DATA_BUS-1:0] data;
        logic [REG_BUS-1:0]  waddr;
        logic [DATA_BUS-1:0] wdata;
    } stage_t;

    function automatic logic is_load(input mem_op_e op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Halfwords need addr[0] = 0, words need addr[1:0] = 0; bytes never fault.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lane);
        return ((op inside {OP_LH, OP_LHU, OP_SH}) && lane[0]) ||
               ((op inside {OP_LW, OP_SW}) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory bus between the MEM stage and memory.
//   master (stage):  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb out;
//                    mem_rdata, mem_ready in
//   slave  (memory): the reverse
interface mem_stage_if import mem_stage_pkg::*; ();

    logic                mem_req;
    logic                mem_we;
    logic [DATA_BUS-1:0] mem_addr;
    logic [DATA_BUS-1:0] mem_wdata;
    logic [3:0]          mem_wstrb;
    logic [DATA_BUS-1:0] mem_rdata;
    logic                mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational byte-lane steering shared by load and store paths.
//   i_op     memory op held in the stage register
//   i_lane   addr[1:0] of the access
//   i_sdata  unshifted store data (rs2)
//   i_rdata  word read from the bus
//   o_wstrb  byte-lane write enables (stores only, else 0)
//   o_wdata  lane-replicated store data
//   o_ldata  extracted and sign/zero-extended load result
module lsu_align
    import mem_stage_pkg::*;
(
    input  mem_op_e             i_op,
    input  logic [1:0]          i_lane,
    input  logic [DATA_BUS-1:0] i_sdata,
    input  logic [DATA_BUS-1:0] i_rdata,
    output logic [3:0]          o_wstrb,
    output logic [DATA_BUS-1:0] o_wdata,
    output logic [DATA_BUS-1:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_wstrb = 4'b0000;
        o_wdata = '0;
        o_ldata = '0;
        w_half  = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_lane)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase

        case (i_op)
            OP_SB: begin
                o_wstrb = 4'b0001 << i_lane;
                o_wdata = {4{i_sdata[7:0]}};
            end
            OP_SH: begin
                o_wstrb = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_sdata[15:0]}};
            end
            OP_SW: begin
                o_wstrb = 4'b1111;
                o_wdata = i_sdata;
            end
            OP_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_ldata = {24'd0, w_byte};
            OP_LH:   o_ldata = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_ldata = {16'd0, w_half};
            OP_LW:   o_ldata = i_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Holds one EX result in stage register S,
// issues its load/store on the data bus, and retires it to the writeback
// registers. Stalls upstream while a bus access is outstanding.
//   clk, rst            clock, synchronous active-high reset
//   i_ex_*              EX result (valid, op, address, store data, rd, ALU value)
//   o_mem_stall         hold upstream; S is not recaptured while high
//   bus                 data-memory bus (master side)
//   o_wb_*              registered writeback to the register file
//   o_err_misaligned    one-cycle pulse after a misaligned op retires
//   o_err_timeout       one-cycle pulse after an access is abandoned
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_ex_valid,
    input  mem_op_e             i_ex_mem_op,
    input  logic [DATA_BUS-1:0] i_ex_mem_addr,
    input  logic [DATA_BUS-1:0] i_ex_mem_data,
    input  logic [REG_BUS-1:0]  i_ex_gprs_waddr,
    input  logic [DATA_BUS-1:0] i_ex_gprs_wdata,
    output logic                o_mem_stall,
    mem_stage_if.master         bus,
    output logic                o_wb_valid,
    output logic [REG_BUS-1:0]  o_wb_waddr,
    output logic [DATA_BUS-1:0] o_wb_wdata,
    output logic                o_err_misaligned,
    output logic                o_err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    stage_t              r_s;
    state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_wb_valid, r_err_mis, r_err_to;
    logic [REG_BUS-1:0]  r_wb_waddr;
    logic [DATA_BUS-1:0] r_wb_wdata;

    logic                w_is_mem, w_mis, w_timeout, w_access, w_req, w_we;
    logic                w_done, w_complete, w_capture, w_wb, w_ex_access;
    logic [3:0]          w_wstrb;
    logic [DATA_BUS-1:0] w_wdata, w_ldata;

    lsu_align u_align (
        .i_op    (r_s.op),
        .i_lane  (r_s.addr[1:0]),
        .i_sdata (r_s.data),
        .i_rdata (bus.mem_rdata),
        .o_wstrb (w_wstrb),
        .o_wdata (w_wdata),
        .o_ldata (w_ldata)
    );

    // ACCESS is only ever entered together with a valid aligned memory op in S,
    // so the state alone qualifies the request.
    assign w_is_mem    = is_load(r_s.op) || is_store(r_s.op);
    assign w_mis       = r_s.valid && w_is_mem && is_misaligned(r_s.op, r_s.addr[1:0]);
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT));
    assign w_access    = (r_state == ST_ACCESS);
    assign w_req       = w_access && !w_timeout;
    assign w_we        = w_req && is_store(r_s.op);
    assign w_done      = w_req && bus.mem_ready;
    assign w_complete  = !w_is_mem || w_mis || w_done || (w_access && w_timeout);
    assign o_mem_stall = r_s.valid && !w_complete;
    assign w_capture   = !o_mem_stall;

    assign w_ex_access = i_ex_valid &&
                         (is_load(i_ex_mem_op) || is_store(i_ex_mem_op)) &&
                         !is_misaligned(i_ex_mem_op, i_ex_mem_addr[1:0]);

    // Only ALU results and successful loads reach the register file; x0 never does.
    assign w_wb = r_s.valid && (r_s.waddr != '0) &&
                  ((r_s.op == OP_NONE) || (is_load(r_s.op) && w_done));

    assign bus.mem_req   = w_req;
    assign bus.mem_we    = w_we;
    assign bus.mem_addr  = {r_s.addr[DATA_BUS-1:2], 2'b00};
    assign bus.mem_wdata = w_wdata;
    assign bus.mem_wstrb = w_we ? w_wstrb : 4'b0000;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_capture) begin
            w_state_nxt = w_ex_access ? ST_ACCESS : ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_req && !bus.mem_ready) begin
            w_cnt_nxt   = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s        <= '0;
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
            r_err_mis  <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_capture) begin
                r_s.valid <= i_ex_valid;
                r_s.op    <= i_ex_mem_op;
                r_s.addr  <= i_ex_mem_addr;
                r_s.data  <= i_ex_mem_data;
                r_s.waddr <= i_ex_gprs_waddr;
                r_s.wdata <= i_ex_gprs_wdata;
            end
            r_wb_valid <= w_wb;
            if (w_wb) begin
                r_wb_waddr <= r_s.waddr;
                r_wb_wdata <= w_is_mem ? w_ldata : r_s.wdata;
            end
            r_err_mis  <= w_mis;
            r_err_to   <= w_access && w_timeout;
        end
    end

    assign o_wb_valid       = r_wb_valid;
    assign o_wb_waddr       = r_wb_waddr;
    assign o_wb_wdata       = r_wb_wdata;
    assign o_err_misaligned = r_err_mis;
    assign o_err_timeout    = r_err_to;

endmodule
